// File: rtl/ysyx_25070198_pkg.sv
// Shared types and widths for the NPC memory arbiter slice.
package ysyx_25070198_pkg;

  localparam int XLEN    = 32;
  localparam int MASK_W  = 4;
  localparam int GNT_IFU = 0;
  localparam int GNT_LSU = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/ysyx_25070198_prio_sel.sv
// Fixed-priority (LSU over IFU) selector with a starvation override for fetch.
module ysyx_25070198_prio_sel
  import ysyx_25070198_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic             ifu_valid,
  input  logic             lsu_valid,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] starve_next
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic force_ifu;

  assign force_ifu = ifu_valid && (starve_cnt == CNT_MAX);

  // grant decision and counter update; counter only advances while fetch is waiting
  always_comb begin
    grant       = 2'b00;
    starve_next = starve_cnt;
    if (lsu_valid && !force_ifu) begin
      grant[GNT_LSU] = 1'b1;
      if (ifu_valid) begin
        starve_next = (starve_cnt == CNT_MAX) ? starve_cnt : (starve_cnt + CNT_ONE);
      end else begin
        starve_next = '0;
      end
    end else if (ifu_valid) begin
      grant[GNT_IFU] = 1'b1;
      starve_next    = '0;
    end else begin
      starve_next = '0;
    end
  end

endmodule

// File: rtl/ysyx_25070198_mem_arbiter.sv
// Shares the single memory port between IFU and LSU with one outstanding transaction.
module ysyx_25070198_mem_arbiter
  import ysyx_25070198_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [XLEN-1:0]   ifu_addr,
  output logic              ifu_resp_valid,
  output logic [XLEN-1:0]   ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [XLEN-1:0]   lsu_addr,
  input  logic              lsu_wen,
  input  logic [XLEN-1:0]   lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [XLEN-1:0]   lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              proto_err
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  state_t            state_r, state_next_s;
  owner_t            owner_r;
  logic [XLEN-1:0]   addr_r, wdata_r;
  logic              wen_r;
  logic [MASK_W-1:0] wmask_r;
  logic [CNT_W-1:0]  starve_cnt_r, starve_next_s;
  logic [1:0]        grant_s;
  logic              accept_ifu_s, accept_lsu_s;
  logic              proto_err_r;

  ysyx_25070198_prio_sel #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_prio_sel (
    .ifu_valid   (ifu_req_valid),
    .lsu_valid   (lsu_req_valid),
    .starve_cnt  (starve_cnt_r),
    .grant       (grant_s),
    .starve_next (starve_next_s)
  );

  // a grant only exists for a valid requester, so a grant in IDLE is a handshake
  assign accept_ifu_s = (state_r == IDLE) && grant_s[GNT_IFU];
  assign accept_lsu_s = (state_r == IDLE) && grant_s[GNT_LSU];

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state and handshake outputs
  always_comb begin
    state_next_s   = state_r;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    case (state_r)
      IDLE: begin
        ifu_req_ready = grant_s[GNT_IFU];
        lsu_req_ready = grant_s[GNT_LSU];
        if (grant_s != 2'b00) begin
          state_next_s = REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = REQ;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          ifu_resp_valid = (owner_r == OWN_IFU);
          lsu_resp_valid = (owner_r == OWN_LSU);
          state_next_s   = IDLE;
        end else begin
          state_next_s = WAIT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // request latch; a fetch carries no write data or byte enables
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_r <= OWN_IFU;
      addr_r  <= '0;
      wen_r   <= 1'b0;
      wdata_r <= '0;
      wmask_r <= '0;
    end else if (accept_lsu_s) begin
      owner_r <= OWN_LSU;
      addr_r  <= lsu_addr;
      wen_r   <= lsu_wen;
      wdata_r <= lsu_wdata;
      wmask_r <= lsu_wmask;
    end else if (accept_ifu_s) begin
      owner_r <= OWN_IFU;
      addr_r  <= ifu_addr;
      wen_r   <= 1'b0;
      wdata_r <= '0;
      wmask_r <= '0;
    end
  end

  // starvation counter only moves on IDLE cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= '0;
    end else if (state_r == IDLE) begin
      starve_cnt_r <= starve_next_s;
    end
  end

  // sticky flag for responses arriving when nothing is outstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err_r <= 1'b0;
    end else if (mem_resp_valid && (state_r != WAIT)) begin
      proto_err_r <= 1'b1;
    end
  end

  assign mem_addr  = addr_r;
  assign mem_wen   = wen_r;
  assign mem_wdata = wdata_r;
  assign mem_wmask = wmask_r;
  assign ifu_rdata = mem_rdata;
  assign lsu_rdata = mem_rdata;
  assign proto_err = proto_err_r;

endmodule

// File: tb/tb_ysyx_25070198_mem_arbiter.sv
// Directed bench for the memory arbiter with a transaction-level reference model.
module tb_ysyx_25070198_mem_arbiter;
  import ysyx_25070198_pkg::*;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, proto_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  always #5 clk = ~clk;

  ysyx_25070198_mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .proto_err(proto_err)
  );

  int n_checks = 0, n_pass = 0, cyc = 0;
  bit check_en = 1'b0;

  // transaction-level model: one outstanding request, issued or not yet issued
  bit          m_busy, m_issued, m_own_lsu, m_perr, m_wen;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wmask;
  int          m_starve;

  // requester agents and memory responder
  int ifu_left, lsu_left;
  bit mem_auto;
  int mem_stall, mem_lat, stall_cnt, lat_cnt;

  // observation logs of DUT activity
  int          grant_q[$], grant_cyc_q[$], ifu_resp_cyc_q[$], lsu_resp_cyc_q[$], mreq_cyc_q[$];
  logic [31:0] mreq_addr_q[$];
  bit          mreq_wen_q[$];
  logic [3:0]  mreq_mask_q[$];
  int          ifu_pulses, lsu_pulses;
  logic [31:0] last_ifu_rdata;
  int          starve_at_ifu_grant;
  bit          starve_watch, starve_pending;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0010_0073 : (a ^ 32'hA5A5_0F0F);
  endfunction

  function automatic bit sel_lsu();
    return lsu_req_valid && !(ifu_req_valid && (m_starve >= STARVE_MAX));
  endfunction

  task automatic clear_logs();
    grant_q.delete(); grant_cyc_q.delete(); ifu_resp_cyc_q.delete(); lsu_resp_cyc_q.delete();
    mreq_cyc_q.delete(); mreq_addr_q.delete(); mreq_wen_q.delete(); mreq_mask_q.delete();
    ifu_pulses = 0; lsu_pulses = 0; last_ifu_rdata = 32'h0;
    starve_at_ifu_grant = -1; starve_pending = 1'b0;
  endtask

  // the single compare point: model expectations against DUT outputs
  task automatic tick_neg();
    bit idle, sl, si, exp_ir, exp_lr;
    @(negedge clk);
    cyc++;
    if (check_en) begin
      idle   = !m_busy;
      sl     = sel_lsu();
      si     = ifu_req_valid && !sl;
      exp_ir = m_busy && m_issued && mem_resp_valid && !m_own_lsu;
      exp_lr = m_busy && m_issued && mem_resp_valid && m_own_lsu;
      chk("ifu_req_ready", ifu_req_ready, idle && si);
      chk("lsu_req_ready", lsu_req_ready, idle && sl);
      chk("mem_req_valid", mem_req_valid, m_busy && !m_issued);
      if (m_busy && !m_issued) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wen", mem_wen, m_wen);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("mem_wmask", mem_wmask, m_wmask);
      end
      chk("ifu_resp_valid", ifu_resp_valid, exp_ir);
      chk("lsu_resp_valid", lsu_resp_valid, exp_lr);
      if (exp_ir) chk("ifu_rdata", ifu_rdata, mem_rdata);
      if (exp_lr) chk("lsu_rdata", lsu_rdata, mem_rdata);
      chk("proto_err", proto_err, m_perr);
      if (starve_pending) begin
        chk("starve_cleared", dut.starve_cnt_r, 32'd0);
        starve_pending = 1'b0;
      end
    end
    if (ifu_req_valid && ifu_req_ready) begin
      grant_q.push_back(1); grant_cyc_q.push_back(cyc);
      if (starve_watch) begin
        starve_at_ifu_grant = int'(dut.starve_cnt_r);
        starve_pending = 1'b1;
      end
    end
    if (lsu_req_valid && lsu_req_ready) begin
      grant_q.push_back(2); grant_cyc_q.push_back(cyc);
    end
    if (ifu_resp_valid) begin
      ifu_pulses++; ifu_resp_cyc_q.push_back(cyc); last_ifu_rdata = ifu_rdata;
    end
    if (lsu_resp_valid) begin
      lsu_pulses++; lsu_resp_cyc_q.push_back(cyc);
    end
    if (mem_req_valid && mem_req_ready) begin
      mreq_cyc_q.push_back(cyc); mreq_addr_q.push_back(mem_addr);
      mreq_wen_q.push_back(mem_wen); mreq_mask_q.push_back(mem_wmask);
    end
  endtask

  // advance the model on the clock edge, then drive the next inputs
  task automatic tick_pos();
    bit idle, sl, si, acc_i, acc_l;
    @(posedge clk);
    idle = !m_busy; sl = sel_lsu(); si = ifu_req_valid && !sl;
    acc_i = 1'b0; acc_l = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_issued = 1'b0; m_own_lsu = 1'b0; m_perr = 1'b0; m_starve = 0;
      m_addr = 32'h0; m_wen = 1'b0; m_wdata = 32'h0; m_wmask = 4'h0;
    end else begin
      if (mem_resp_valid && !(m_busy && m_issued)) m_perr = 1'b1;
      if (idle) begin
        if (sl) begin
          acc_l = 1'b1; m_busy = 1'b1; m_issued = 1'b0; m_own_lsu = 1'b1;
          m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
          if (ifu_req_valid) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : m_starve;
          else m_starve = 0;
        end else if (si) begin
          acc_i = 1'b1; m_busy = 1'b1; m_issued = 1'b0; m_own_lsu = 1'b0;
          m_addr = ifu_addr; m_wen = 1'b0; m_wdata = 32'h0; m_wmask = 4'h0; m_starve = 0;
        end else if (!ifu_req_valid) begin
          m_starve = 0;
        end
      end else if (!m_issued) begin
        if (mem_req_ready) begin m_issued = 1'b1; lat_cnt = 0; end
      end else if (mem_resp_valid) begin
        m_busy = 1'b0; m_issued = 1'b0;
      end
    end
    #1;
    if (acc_i) begin ifu_left--; ifu_addr += 32'd4; end
    if (acc_l) begin lsu_left--; lsu_addr += 32'd4; lsu_wdata += 32'd1; end
    if (acc_i || acc_l) stall_cnt = 0;
    ifu_req_valid = (ifu_left > 0);
    lsu_req_valid = (lsu_left > 0);
    if (mem_auto) begin
      if (m_busy && !m_issued) begin mem_req_ready = (stall_cnt >= mem_stall); stall_cnt++; end
      else mem_req_ready = 1'b0;
      if (m_busy && m_issued) begin lat_cnt++; mem_resp_valid = (lat_cnt == mem_lat); end
      else mem_resp_valid = 1'b0;
      mem_rdata = rdata_of(m_addr);
    end
  endtask

  task automatic step();
    tick_neg(); tick_pos();
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int n = 0;
    while ((m_busy || ifu_left > 0 || lsu_left > 0) && n < budget) begin step(); n++; end
    chk({name, "_within_budget"}, (n < budget), 32'd1);
    step();
  endtask

  int exp_starve[6] = '{2, 2, 2, 2, 1, 2};
  int before_ifu;

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_addr = 32'h0;
    lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    mem_auto = 1'b1; mem_stall = 0; mem_lat = 1; stall_cnt = 0; lat_cnt = 0;
    ifu_left = 0; lsu_left = 0; starve_watch = 1'b0;
    m_busy = 1'b0; m_issued = 1'b0; m_own_lsu = 1'b0; m_perr = 1'b0; m_starve = 0;
    m_addr = 32'h0; m_wen = 1'b0; m_wdata = 32'h0; m_wmask = 4'h0;
    clear_logs();
    repeat (2) step();
    rst = 1'b0;
    check_en = 1'b1;

    // reset values
    tick_neg();
    chk("rst_mem_req_valid", mem_req_valid, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wen", mem_wen, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wmask", mem_wmask, 32'h0);
    chk("rst_resp_valids", {ifu_resp_valid, lsu_resp_valid}, 32'd0);
    chk("rst_proto_err", proto_err, 32'd0);
    tick_pos();

    // single fetch
    clear_logs();
    ifu_addr = 32'h8000_0000; ifu_left = 1; ifu_req_valid = 1'b1;
    run_until_idle(20, "fetch");
    chk("fetch_grant", qget(grant_q, 0), 32'd1);
    chk("fetch_mreq_at_n1", qget(mreq_cyc_q, 0) - qget(grant_cyc_q, 0), 32'd1);
    chk("fetch_mem_addr", (mreq_addr_q.size() > 0) ? mreq_addr_q[0] : 32'hFFFF_FFFF, 32'h8000_0000);
    chk("fetch_mem_wen", (mreq_wen_q.size() > 0) ? mreq_wen_q[0] : 1'b1, 32'd0);
    chk("fetch_resp_at_n2", qget(ifu_resp_cyc_q, 0) - qget(grant_cyc_q, 0), 32'd2);
    chk("fetch_rdata", last_ifu_rdata, 32'h0010_0073);
    chk("fetch_lsu_pulses", lsu_pulses, 32'd0);

    // simultaneous requests: LSU store first, IFU on the next IDLE cycle
    clear_logs();
    ifu_addr = 32'h8000_0004; ifu_left = 1; ifu_req_valid = 1'b1;
    lsu_addr = 32'h8000_0100; lsu_wen = 1'b1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    lsu_left = 1; lsu_req_valid = 1'b1;
    run_until_idle(30, "simul");
    chk("simul_first_lsu", qget(grant_q, 0), 32'd2);
    chk("simul_second_ifu", qget(grant_q, 1), 32'd1);
    chk("simul_ifu_next_idle", qget(grant_cyc_q, 1) - qget(grant_cyc_q, 0), 32'd3);
    chk("simul_mem_addr", (mreq_addr_q.size() > 0) ? mreq_addr_q[0] : 32'h0, 32'h8000_0100);
    chk("simul_mem_wen", (mreq_wen_q.size() > 0) ? mreq_wen_q[0] : 1'b0, 32'd1);
    chk("simul_mem_wmask", (mreq_mask_q.size() > 0) ? mreq_mask_q[0] : 4'h0, 32'hF);

    // starvation: four LSU grants, then IFU is forced
    clear_logs();
    starve_watch = 1'b1;
    lsu_addr = 32'h8000_0200; lsu_wen = 1'b0; lsu_wmask = 4'h0;
    ifu_left = 1; ifu_req_valid = 1'b1; lsu_left = 5; lsu_req_valid = 1'b1;
    run_until_idle(60, "starve");
    starve_watch = 1'b0;
    chk("starve_grant_count", grant_q.size(), 32'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("starve_grant_%0d", i), qget(grant_q, i), exp_starve[i]);
    before_ifu = 0;
    foreach (lsu_resp_cyc_q[i]) if (lsu_resp_cyc_q[i] < qget(grant_cyc_q, 4)) before_ifu++;
    chk("starve_lsu_before_ifu", before_ifu, 32'd4);
    chk("starve_cnt_at_force", starve_at_ifu_grant, 32'd4);

    // downstream stall of 3 cycles and 2-cycle response
    clear_logs();
    mem_stall = 3; mem_lat = 2;
    lsu_addr = 32'h8000_0300; lsu_wen = 1'b1; lsu_wdata = 32'h1234_5678; lsu_wmask = 4'h3;
    lsu_left = 1; lsu_req_valid = 1'b1;
    run_until_idle(30, "stall");
    chk("stall_one_pulse", lsu_pulses, 32'd1);
    chk("stall_latency", qget(lsu_resp_cyc_q, 0) - qget(grant_cyc_q, 0), 32'd6);
    mem_stall = 0; mem_lat = 1;

    // response coinciding with ready in REQ is stray
    clear_logs();
    mem_auto = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    lsu_addr = 32'h8000_0400; lsu_wen = 1'b0; lsu_left = 1; lsu_req_valid = 1'b1;
    step();
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    step();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    step();
    mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0400;
    tick_neg();
    chk("stray_real_resp", lsu_resp_valid, 32'd1);
    chk("stray_rdata", lsu_rdata, 32'h0000_0400);
    chk("stray_proto_err", proto_err, 32'd1);
    tick_pos();
    mem_resp_valid = 1'b0;
    step();
    chk("stray_pulses", lsu_pulses, 32'd1);

    // reset while waiting, then a late response
    rst = 1'b1; step(); rst = 1'b0;
    mem_auto = 1'b1; mem_lat = 20;
    clear_logs();
    lsu_addr = 32'h8000_0500; lsu_left = 1; lsu_req_valid = 1'b1;
    for (int n = 0; n < 10 && !(m_busy && m_issued); n++) step();
    chk("reach_wait", (m_busy && m_issued), 32'd1);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    tick_neg();
    chk("mid_rst_state", dut.state_r, IDLE);
    chk("mid_rst_mem_req_valid", mem_req_valid, 32'd0);
    chk("mid_rst_mem_addr", mem_addr, 32'h0);
    chk("mid_rst_mem_fields", {mem_wen, mem_wmask}, 32'h0);
    chk("mid_rst_mem_wdata", mem_wdata, 32'h0);
    chk("mid_rst_resp", {ifu_resp_valid, lsu_resp_valid}, 32'd0);
    tick_pos();
    mem_auto = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
    step();
    mem_resp_valid = 1'b0;
    repeat (3) step();
    tick_neg();
    chk("late_resp_proto_err", proto_err, 32'd1);
    chk("late_resp_no_pulse", lsu_pulses, 32'd0);
    tick_pos();
    rst = 1'b1; step(); rst = 1'b0;
    tick_neg();
    chk("proto_err_cleared", proto_err, 32'd0);
    tick_pos();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
